// File: rtl/bin2ascii_stream_if.sv
// Handshake bundle for bin2ascii_stream: value input side and ASCII byte output side.
interface bin2ascii_stream_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_byte, out_valid, busy
  );
endinterface

// File: rtl/bin2ascii_stream.sv
// Binary to ASCII decimal formatter: sequential double-dabble conversion, then
// byte-serial output with optional sign, leading-zero suppression and CR/LF.
module bin2ascii_stream #(
  parameter int DATA_W      = 16,
  parameter int DIGITS      = 5,
  parameter bit SIGNED      = 1'b0,
  parameter bit SUPPRESS_LZ = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  bin2ascii_stream_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_SIGN, S_DIGIT, S_CR, S_LF
  } state_t;

  state_t            state_q;
  logic [BW-1:0]     bcd_q;
  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     ptr_q;
  logic              neg_q;
  logic [7:0]        out_byte_q;
  logic              out_valid_q;

  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_d;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] mag_d;
  logic [PW-1:0]     lead_ptr_d;
  logic              xfer;

  function automatic logic [7:0] digit_ascii(input logic [BW-1:0] b, input logic [PW-1:0] p);
    return {4'h3, b[4*int'(p) +: 4]};
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_d   = (bcd_adj << 1) | {{(BW-1){1'b0}}, shift_q[DATA_W-1]};
    shift_d = shift_q << 1;

    // Pointer taken from the post-step BCD so the last CONVERT edge can load the first byte.
    lead_ptr_d = '0;
    if (SUPPRESS_LZ) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (bcd_d[4*i +: 4] != 4'd0) lead_ptr_d = PW'(i);
      end
    end else begin
      lead_ptr_d = PW'(DIGITS - 1);
    end

    mag_d = bus.in_data;
    if (SIGNED && bus.in_data[DATA_W-1]) mag_d = ~bus.in_data + DATA_W'(1);

    xfer = out_valid_q && bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      neg_q       <= 1'b0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            shift_q <= mag_d;
            neg_q   <= SIGNED && bus.in_data[DATA_W-1];
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            ptr_q       <= lead_ptr_d;
            out_valid_q <= 1'b1;
            if (neg_q) begin
              out_byte_q <= 8'h2D;
              state_q    <= S_SIGN;
            end else begin
              out_byte_q <= digit_ascii(bcd_d, lead_ptr_d);
              state_q    <= S_DIGIT;
            end
          end
        end
        S_SIGN: begin
          if (xfer) begin
            out_byte_q <= digit_ascii(bcd_q, ptr_q);
            state_q    <= S_DIGIT;
          end
        end
        S_DIGIT: begin
          if (xfer) begin
            if (ptr_q == '0) begin
              if (APPEND_CRLF) begin
                out_byte_q <= 8'h0D;
                state_q    <= S_CR;
              end else begin
                out_byte_q  <= '0;
                out_valid_q <= 1'b0;
                state_q     <= S_IDLE;
              end
            end else begin
              ptr_q      <= ptr_q - PW'(1);
              out_byte_q <= digit_ascii(bcd_q, ptr_q - PW'(1));
            end
          end
        end
        S_CR: begin
          if (xfer) begin
            out_byte_q <= 8'h0A;
            state_q    <= S_LF;
          end
        end
        S_LF: begin
          if (xfer) begin
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_byte  = out_byte_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bin2ascii_stream.sv
// Bench for bin2ascii_stream: three parameter variants checked against hand-written strings.
module tb_bin2ascii_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2ascii_stream_if #(.DATA_W(16)) if_def ();
  bin2ascii_stream_if #(.DATA_W(16)) if_raw ();
  bin2ascii_stream_if #(.DATA_W(16)) if_sgn ();

  bin2ascii_stream #(.DATA_W(16), .DIGITS(5)) u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
  bin2ascii_stream #(.DATA_W(16), .DIGITS(5), .SUPPRESS_LZ(1'b0), .APPEND_CRLF(1'b0))
    u_raw (.clk(clk), .rst_n(rst_n), .bus(if_raw));
  bin2ascii_stream #(.DATA_W(16), .DIGITS(5), .SIGNED(1'b1)) u_sgn (.clk(clk), .rst_n(rst_n), .bus(if_sgn));

  int unsigned sel = 0;
  logic        iv = 1'b0;
  logic [15:0] idata = '0;
  logic        ordy = 1'b0;

  assign if_def.in_valid = iv && (sel == 0);
  assign if_raw.in_valid = iv && (sel == 1);
  assign if_sgn.in_valid = iv && (sel == 2);
  assign if_def.in_data = idata;
  assign if_raw.in_data = idata;
  assign if_sgn.in_data = idata;
  assign if_def.out_ready = ordy;
  assign if_raw.out_ready = ordy;
  assign if_sgn.out_ready = ordy;

  logic [7:0] ob;
  logic ov, ir, bz;
  always_comb begin
    ob = if_def.out_byte; ov = if_def.out_valid; ir = if_def.in_ready; bz = if_def.busy;
    case (sel)
      1: begin ob = if_raw.out_byte; ov = if_raw.out_valid; ir = if_raw.in_ready; bz = if_raw.busy; end
      2: begin ob = if_sgn.out_byte; ov = if_sgn.out_valid; ir = if_sgn.in_ready; bz = if_sgn.busy; end
      default: ;
    endcase
  end

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input string s, input bit crlf, input int unsigned k);
    if (k < s.len()) return s[k];
    if (crlf && k == s.len()) return 8'h0D;
    return 8'h0A;
  endfunction

  // Accept one value, check latency, collect and compare the whole string.
  task automatic send(input int unsigned d, input logic [15:0] v, input string s,
                      input bit crlf, input bit rnd, input bit pulse);
    int unsigned total, idx, n, lat, extra;
    bit held;
    logic [7:0] held_byte;
    total = s.len() + (crlf ? 2 : 0);
    @(negedge clk);
    sel = d;
    ordy = !rnd;
    #1 chk("in_ready_idle", 32'(ir), 32'd1);
    idata = v; iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    chk("busy_after_accept", 32'(bz), 32'd1);
    chk("in_ready_after_accept", 32'(ir), 32'd0);
    lat = 0;
    for (int unsigned c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov) begin lat = c; break; end
    end
    chk("first_byte_latency", lat, 32'd16);
    idx = 0; n = 0; held = 0; held_byte = '0;
    while (idx < total && n < 200) begin
      @(negedge clk);
      n++;
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) chk("byte_hold", 32'(ob), 32'(held_byte));
      if (!rnd) chk("stream_gapless", 32'(ov), 32'd1);
      if (pulse && n == 3) begin
        iv = 1'b1; idata = 16'd999;
        #1 chk("in_ready_while_busy", 32'(ir), 32'd0);
      end
      if (pulse && n == 4) begin iv = 1'b0; idata = v; end
      if (ov && ordy) begin
        chk($sformatf("byte%0d_of_%0d", idx, v), 32'(ob), 32'(exp_byte(s, crlf, idx)));
        idx++;
      end
      held = ov && !ordy;
      held_byte = ob;
      @(posedge clk);
    end
    iv = 1'b0;
    if (idx < total) chk("stream_timeout", idx, total);
    #1;
    chk("valid_low_at_end", 32'(ov), 32'd0);
    chk("busy_low_at_end", 32'(bz), 32'd0);
    chk("in_ready_at_end", 32'(ir), 32'd1);
    if (pulse) begin
      extra = 0;
      for (int unsigned c = 0; c < 24; c++) begin
        @(negedge clk);
        if (ov || bz) extra++;
      end
      chk("ignored_input_not_emitted", extra, 32'd0);
    end
    ordy = 1'b0;
  endtask

  typedef struct {
    int unsigned dut;
    logic [15:0] val;
    string       digits;
    bit          crlf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int unsigned lat, quiet;
    vecs[0] = '{0, 16'd1234,  "1234",   1'b1};
    vecs[1] = '{0, 16'd0,     "0",      1'b1};
    vecs[2] = '{0, 16'd65535, "65535",  1'b1};
    vecs[3] = '{0, 16'd10000, "10000",  1'b1};
    vecs[4] = '{1, 16'd42,    "00042",  1'b0};
    vecs[5] = '{1, 16'd0,     "00000",  1'b0};
    vecs[6] = '{2, 16'h8000,  "-32768", 1'b1};
    vecs[7] = '{2, 16'hFFFF,  "-1",     1'b1};
    vecs[8] = '{2, 16'h7FFF,  "32767",  1'b1};
    vecs[9] = '{2, 16'd5,     "5",      1'b1};

    repeat (3) @(negedge clk);
    for (int unsigned d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk($sformatf("reset_valid_dut%0d", d), 32'(ov), 32'd0);
      chk($sformatf("reset_byte_dut%0d", d), 32'(ob), 32'd0);
      chk($sformatf("reset_busy_dut%0d", d), 32'(bz), 32'd0);
      chk($sformatf("reset_in_ready_dut%0d", d), 32'(ir), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int unsigned i = 0; i < 10; i++)
      send(vecs[i].dut, vecs[i].val, vecs[i].digits, vecs[i].crlf, 1'b0, 1'b0);

    send(0, 16'd1234, "1234", 1'b1, 1'b1, 1'b1);
    send(2, 16'h8000, "-32768", 1'b1, 1'b1, 1'b0);

    // Reset in the middle of "1234": after two digits have transferred.
    @(negedge clk);
    sel = 0; ordy = 1'b1;
    idata = 16'd1234; iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    lat = 0;
    for (int unsigned c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov) begin lat = c; break; end
    end
    chk("rst_seq_latency", lat, 32'd16);
    repeat (2) @(posedge clk);
    #1 chk("rst_seq_third_byte", 32'(ob), 32'h33);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(ov), 32'd0);
    chk("midreset_busy", 32'(bz), 32'd0);
    chk("midreset_byte", 32'(ob), 32'd0);
    quiet = 0;
    repeat (3) begin @(negedge clk); if (ov) quiet++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (ov || bz) quiet++; end
    chk("no_bytes_after_reset", quiet, 32'd0);
    send(0, 16'd7, "7", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
